gate_vec_sequencer: RTL and testbench
=====================================

Name: gate_vec_sequencer

Overview:
- Upstream stimulus and downstream result-capture stage for the 3-input AND-OR gate block (m = x·z + y·z).
- Steps through all eight x/y/z input combinations in the team's fixed truth-table order and drives them onto the gate inputs.
- Samples the gate output m for each combination, assembles an 8-bit truth-table word and compares it against an expected constant.
- Lets the gate block be exercised and checked in hardware by a single start pulse.

Parameters:
- HOLD_CYCLES, 1, cycles each vector is held before m is sampled; legal range 1..15.
- EXPECTED, 8'hE0, expected truth-table word; bit i is the m value for sequence step i.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to run one sweep.
- m_in  input  1  output of the gate block under test.
- x_out  output  1  gate input x.
- y_out  output  1  gate input y.
- z_out  output  1  gate input z.
- busy  output  1  high while a sweep is in progress.
- done  output  1  high once a sweep has completed; held until the next accepted start or rst.
- pass  output  1  valid when done=1; 1 means result equals EXPECTED.
- result  output  8  captured truth-table word.
- step  output  3  current sequence index.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high (rst).
- Reset values: all outputs 0 (x/y/z_out=0, busy=0, done=0, pass=0, result=8'h00, step=0); state=IDLE.
- Vector order, as {x,y,z} by step 0..7: 000, 100, 010, 001, 110, 011, 101, 111.
- State machine:
  - IDLE: outputs hold. start=1 at edge k moves to DRIVE at k+1, with step=0, result=0, done=0, pass=0, busy=1.
  - DRIVE: x/y/z_out = vector[step]. Remains for exactly HOLD_CYCLES cycles (internal 4-bit hold counter), then moves to SAMPLE.
  - SAMPLE: vector is still driven. On the closing edge, result[step] <= m_in.
    - If step=7, move to DONE.
    - Otherwise step increments and the state returns to DRIVE.
  - DONE: busy=0, done=1, pass=(result==EXPECTED), registered on DONE entry. x/y/z_out return to 000. start=1 re-enters DRIVE as from IDLE.
- Latency: each step lasts HOLD_CYCLES+1 cycles. done rises 8*(HOLD_CYCLES+1) cycles after the accepting start edge; with the default HOLD_CYCLES, 16 cycles.
- Boundary conditions:
  - start while busy=1: ignored.
  - start coincident with rst: rst wins.
  - rst mid-sweep: returns everything to reset values on the next edge; the partial result is discarded.
  - step wrap: never wraps; step 7 always exits to DONE.
  - m_in is only sampled in SAMPLE; it is ignored in all other states.

Optional Feature:
- Macro: GATE_VEC_SEQ_STOP_ON_MISMATCH_EN.
- Defined: in SAMPLE, if m_in != EXPECTED[step], go directly to DONE with pass=0. step holds the failing index; result holds the bits captured so far, including the failing bit. Remaining vectors are not driven.
- Undefined: all eight vectors always run; pass is evaluated only at the end.

Decomposition:
- Package gate_vec_pkg:
  - state enum (IDLE, DRIVE, SAMPLE, DONE);
  - 8-entry 3-bit vector-order constant;
  - default EXPECTED constant 8'hE0;
  - hold-counter width constant (4).
- One sub-module, gate_vec_rom: combinational step[2:0] -> {x,y,z}, using the package constant.

Test Plan:
- Basic sweep: rst, then start with correct gate attached, HOLD_CYCLES=1 -> x/y/z follow 000,100,010,001,110,011,101,111 every 2 cycles; done=1 at cycle 16 after start; result=8'hE0; pass=1.
- Faulty gate: m_in forced 1 at step 0 -> result=8'hE1, pass=0. With GATE_VEC_SEQ_STOP_ON_MISMATCH_EN: done at cycle 2, step=0, result=8'h01, pass=0.
- HOLD_CYCLES=3: each vector held 3 cycles plus 1 sample cycle -> done at cycle 32; m_in toggling outside SAMPLE has no effect on result.
- start pulses at cycles 3 and 9 of a running sweep -> ignored; single done at cycle 16. Start in DONE -> done drops next cycle and a new sweep begins with result=0.
- rst asserted at cycle 7 of a sweep -> next edge: busy=0, result=0, step=0, x/y/z=000; start plus rst in the same cycle -> stays IDLE.

Source files
------------

// File: rtl/gate_vec_pkg.sv
// Shared types and constants for the AND-OR gate vector sequencer.
// Holds the state encoding, the fixed vector order and the default expected word.
package gate_vec_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } state_t;

    // Width of the per-vector hold counter (HOLD_CYCLES up to 15).
    localparam int HOLD_W = 4;

    // Expected truth-table word for m = x&z | y&z in the order below.
    localparam logic [7:0] EXPECTED_DEFAULT = 8'hE0;

    // {x,y,z} per step; entry [0] is step 0.
    localparam logic [7:0][2:0] VEC_ORDER = {
        3'b111,
        3'b101,
        3'b011,
        3'b110,
        3'b001,
        3'b010,
        3'b100,
        3'b000
    };

endpackage

// File: rtl/gate_vec_rom.sv
// Step index to {x,y,z} lookup for the gate vector sequencer.
// Purely combinational view of the fixed vector order.
module gate_vec_rom
    import gate_vec_pkg::*;
(
    input  logic [2:0] addr,
    output logic [2:0] xyz
);

    // Table lookup of the vector for the requested step.
    always_comb begin
        xyz = VEC_ORDER[addr];
    end

endmodule

// File: rtl/gate_vec_sequencer.sv
// Sweeps all eight x/y/z vectors into the AND-OR gate, captures m, checks it.
// Optional macro GATE_VEC_SEQ_STOP_ON_MISMATCH_EN ends a sweep at the first bad bit.
module gate_vec_sequencer
    import gate_vec_pkg::*;
#(
    parameter int         HOLD_CYCLES = 1,
    parameter logic [7:0] EXPECTED    = EXPECTED_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       m_in,
    output logic       x_out,
    output logic       y_out,
    output logic       z_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] result,
    output logic [2:0] step
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    state_t            state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [2:0]        rom_addr;
    logic [2:0]        rom_xyz;
    logic [7:0]        captured;

    gate_vec_rom u_rom (
        .addr (rom_addr),
        .xyz  (rom_xyz)
    );

    // Address the vector to be loaded next: step+1 when leaving SAMPLE, else step 0.
    always_comb begin
        rom_addr = 3'd0;
        if (state == SAMPLE) begin
            rom_addr = step + 3'd1;
        end
    end

    // Result word with the bit for the current step replaced by m_in.
    always_comb begin
        captured       = result;
        captured[step] = m_in;
    end

    // Sequencer FSM with registered gate inputs and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            hold_cnt <= '0;
            x_out    <= 1'b0;
            y_out    <= 1'b0;
            z_out    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            result   <= 8'h00;
            step     <= 3'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= DRIVE;
                        hold_cnt <= '0;
                        step     <= 3'd0;
                        result   <= 8'h00;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        pass     <= 1'b0;
                        {x_out, y_out, z_out} <= rom_xyz;
                    end
                end
                DRIVE: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state    <= SAMPLE;
                        hold_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                SAMPLE: begin
                    result <= captured;
`ifdef GATE_VEC_SEQ_STOP_ON_MISMATCH_EN
                    if (m_in != EXPECTED[step]) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= 1'b0;
                        {x_out, y_out, z_out} <= 3'b000;
                    end else if (step == 3'd7) begin
`else
                    if (step == 3'd7) begin
`endif
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (captured == EXPECTED);
                        {x_out, y_out, z_out} <= 3'b000;
                    end else begin
                        state    <= DRIVE;
                        hold_cnt <= '0;
                        step     <= step + 3'd1;
                        {x_out, y_out, z_out} <= rom_xyz;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_vec_sequencer.sv
// Self-checking bench for gate_vec_sequencer (HOLD_CYCLES=1 and =3 instances).
// Models the gate plus injectable faults; expectations come from sweep rules.
module tb_gate_vec_sequencer;

    localparam int H1 = 1;
    localparam int H3 = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       start1 = 1'b0;
    logic       m1;
    logic       x1, y1, z1, busy1, done1, pass1;
    logic [7:0] result1;
    logic [2:0] step1;
    logic [7:0] flip1 = 8'h00;

    logic       start3 = 1'b0;
    logic       m3 = 1'b0;
    logic       x3, y3, z3, busy3, done3, pass3;
    logic [7:0] result3;
    logic [2:0] step3;

    int n_vec = 0;
    int n_err = 0;

    logic [2:0] vec_tab [8] = '{
        3'b000, 3'b100, 3'b010, 3'b001,
        3'b110, 3'b011, 3'b101, 3'b111
    };

    typedef struct {
        logic [7:0] flip;
        logic [7:0] res;
        logic       pass;
        logic [2:0] step;
        int         cyc;
        bit         pulses;
    } vec_t;

    vec_t tbl [6];

    always #5 clk = ~clk;

    gate_vec_sequencer #(.HOLD_CYCLES(H1)) dut1 (
        .clk    (clk),
        .rst    (rst),
        .start  (start1),
        .m_in   (m1),
        .x_out  (x1),
        .y_out  (y1),
        .z_out  (z1),
        .busy   (busy1),
        .done   (done1),
        .pass   (pass1),
        .result (result1),
        .step   (step1)
    );

    gate_vec_sequencer #(.HOLD_CYCLES(H3)) dut3 (
        .clk    (clk),
        .rst    (rst),
        .start  (start3),
        .m_in   (m3),
        .x_out  (x3),
        .y_out  (y3),
        .z_out  (z3),
        .busy   (busy3),
        .done   (done3),
        .pass   (pass3),
        .result (result3),
        .step   (step3)
    );

    function automatic logic gate(input logic [2:0] v);
        return (v[2] & v[0]) | (v[1] & v[0]);
    endfunction

    function automatic int vidx(input logic [2:0] v);
        int r;
        r = 0;
        for (int i = 0; i < 8; i++)
            if (vec_tab[i] == v) r = i;
        return r;
    endfunction

    // Gate under test for dut1, with a per-vector fault mask.
    always_comb begin
        m1 = gate({x1, y1, z1}) ^ flip1[vidx({x1, y1, z1})];
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model(input logic [7:0] flip, output logic [7:0] r,
                         output logic p, output logic [2:0] s,
                         output int cyc);
        logic [7:0] good;
        for (int i = 0; i < 8; i++) good[i] = gate(vec_tab[i]);
        r   = good ^ flip;
        p   = (flip == 8'h00);
        s   = 3'd7;
        cyc = 8 * (H1 + 1);
`ifdef GATE_VEC_SEQ_STOP_ON_MISMATCH_EN
        if (flip != 8'h00) begin
            int f;
            f = -1;
            for (int i = 0; i < 8; i++)
                if (flip[i] && f < 0) f = i;
            for (int j = 0; j < 8; j++)
                if (j > f) r[j] = 1'b0;
            s   = 3'(f);
            cyc = (f + 1) * (H1 + 1);
        end
`endif
    endtask

    task automatic sweep1(input string nm, input logic [7:0] flip,
                          input logic [7:0] er, input logic ep,
                          input logic [2:0] es, input int ecyc,
                          input bit pulses);
        flip1 = flip;
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        for (int c = 0; c < ecyc; c++) begin
            if (c == 0) chk({nm, " result_clr"}, 32'(result1), 32'h0);
            chk({nm, " busy_done"}, 32'({busy1, done1}), 32'b10);
            chk({nm, " xyz"}, 32'({x1, y1, z1}), 32'(vec_tab[c / (H1 + 1)]));
            chk({nm, " step"}, 32'(step1), 32'(c / (H1 + 1)));
            start1 = pulses && (c == 3 || c == 9);
            @(negedge clk);
        end
        start1 = 1'b0;
        chk({nm, " end_busy_done"}, 32'({busy1, done1}), 32'b01);
        chk({nm, " end_result"}, 32'(result1), 32'(er));
        chk({nm, " end_pass"}, 32'(pass1), 32'(ep));
        chk({nm, " end_step"}, 32'(step1), 32'(es));
        chk({nm, " end_xyz"}, 32'({x1, y1, z1}), 32'h0);
    endtask

    task automatic sweep3();
        @(negedge clk) start3 = 1'b1;
        @(negedge clk) start3 = 1'b0;
        for (int c = 0; c < 8 * (H3 + 1); c++) begin
            chk("h3 busy", 32'(busy3), 32'h1);
            chk("h3 xyz", 32'({x3, y3, z3}), 32'(vec_tab[c / (H3 + 1)]));
            if (c % (H3 + 1) == H3) m3 = gate({x3, y3, z3});
            else m3 = 1'($urandom);
            @(negedge clk);
        end
        chk("h3 done", 32'({busy3, done3}), 32'b01);
        chk("h3 result", 32'(result3), 32'hE0);
        chk("h3 pass", 32'(pass3), 32'h1);
    endtask

    initial begin
        logic [7:0] rr, rf;
        logic       rp;
        logic [2:0] rs;
        int         rc;

`ifdef GATE_VEC_SEQ_STOP_ON_MISMATCH_EN
        tbl[0] = '{8'h00, 8'hE0, 1'b1, 3'd7, 16, 1'b1};
        tbl[1] = '{8'h01, 8'h01, 1'b0, 3'd0, 2,  1'b0};
        tbl[2] = '{8'h80, 8'h60, 1'b0, 3'd7, 16, 1'b0};
        tbl[3] = '{8'h20, 8'h00, 1'b0, 3'd5, 12, 1'b1};
        tbl[4] = '{8'hFF, 8'h01, 1'b0, 3'd0, 2,  1'b0};
        tbl[5] = '{8'hE0, 8'h00, 1'b0, 3'd5, 12, 1'b0};
`else
        tbl[0] = '{8'h00, 8'hE0, 1'b1, 3'd7, 16, 1'b1};
        tbl[1] = '{8'h01, 8'hE1, 1'b0, 3'd7, 16, 1'b0};
        tbl[2] = '{8'h80, 8'h60, 1'b0, 3'd7, 16, 1'b0};
        tbl[3] = '{8'h20, 8'hC0, 1'b0, 3'd7, 16, 1'b1};
        tbl[4] = '{8'hFF, 8'h1F, 1'b0, 3'd7, 16, 1'b0};
        tbl[5] = '{8'hE0, 8'h00, 1'b0, 3'd7, 16, 1'b0};
`endif

        repeat (2) @(negedge clk);
        chk("rst outs1", 32'({x1, y1, z1, busy1, done1, pass1}), 32'h0);
        chk("rst result1", 32'(result1), 32'h0);
        chk("rst step1", 32'(step1), 32'h0);
        chk("rst outs3", 32'({x3, y3, z3, busy3, done3, pass3}), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle busy", 32'({busy1, done1}), 32'b00);

        for (int i = 0; i < 6; i++)
            sweep1($sformatf("tbl%0d", i), tbl[i].flip, tbl[i].res,
                   tbl[i].pass, tbl[i].step, tbl[i].cyc, tbl[i].pulses);

        for (int i = 0; i < 12; i++) begin
            rf = ($urandom_range(2) == 0) ? 8'h00 : 8'($urandom);
            model(rf, rr, rp, rs, rc);
            sweep1($sformatf("rnd%0d", i), rf, rr, rp, rs, rc,
                   1'($urandom));
        end

        sweep3();

        flip1 = 8'h00;
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        repeat (7) @(negedge clk);
        chk("mid busy", 32'(busy1), 32'h1);
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        chk("mid rst outs", 32'({x1, y1, z1, busy1, done1, pass1}), 32'h0);
        chk("mid rst result", 32'(result1), 32'h0);
        chk("mid rst step", 32'(step1), 32'h0);
        @(negedge clk);
        chk("mid rst idle", 32'(busy1), 32'h0);

        rst = 1'b1;
        start1 = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start1 = 1'b0;
        chk("rst+start busy", 32'({busy1, done1}), 32'b00);
        @(negedge clk);
        chk("rst+start idle", 32'({busy1, x1, y1, z1}), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
